// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - data RAM arbiter between processor core and host port
//
// Shares one single-port synchronous RAM (1-cycle read latency) between the
// core Dmem interface and a host port (program loader / debug readback).
// One access is granted per cycle; read data is returned to its owner one
// cycle after the grant. The host can lock the RAM for exclusive bursts.
//
// Optional build macro: DMEM_ARB_RR_EN
//   undefined : core has fixed priority, host forced through after
//               STARVE_LIMIT consecutive lost cycles
//   defined   : contention resolved round-robin, STARVE_LIMIT ignored
//
// Ports:
//   clock, reset              clock and synchronous active-low reset
//   core_req/we/addr/wdata    core access request (held until granted)
//   core_gnt, core_stall      core grant (comb) and stall
//   core_rdata, core_rvalid   core read return
//   host_req/we/addr/wdata    host access request (held until granted)
//   host_lock                 host asks for exclusive ownership
//   host_gnt                  host grant (comb)
//   host_rdata, host_rvalid   host read return
//   host_locked               exclusive ownership held by host
//   mem_addr/wdata/wren, mem_q  RAM side
module dmem_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              host_locked,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  typedef enum logic {ST_ARB, ST_LOCKED} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              core_rvalid_q, core_rvalid_d;
  logic              host_rvalid_q, host_rvalid_d;
  logic              contended;

`ifdef DMEM_ARB_RR_EN
  // 1 when the host won the most recent contended cycle
  logic              last_host_q, last_host_d;
`else
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  logic [3:0]        starve_q, starve_d;
`endif

  assign contended = core_req && host_req;

  always_comb begin
    state_d  = state_q;
    core_gnt = 1'b0;
    host_gnt = 1'b0;
`ifdef DMEM_ARB_RR_EN
    last_host_d = last_host_q;
`endif
    // Grants are forced low while reset is held
    if (reset) begin
      case (state_q)
        ST_ARB: begin
          if (contended) begin
`ifdef DMEM_ARB_RR_EN
            host_gnt    = !last_host_q;
            last_host_d = host_gnt;
`else
            host_gnt = (starve_q == STARVE_MAX);
`endif
            core_gnt = !host_gnt;
          end else begin
            core_gnt = core_req;
            host_gnt = host_req;
          end
          if (host_lock && host_gnt) state_d = ST_LOCKED;
        end
        ST_LOCKED: begin
          host_gnt = host_req;
          if (!host_lock) state_d = ST_ARB;
        end
        default: state_d = ST_ARB;
      endcase
    end

`ifndef DMEM_ARB_RR_EN
    if (host_req && !host_gnt)
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 4'd1;
    else
      starve_d = 4'd0;
`endif

    // Idle cycles keep the last granted address on the RAM bus
    if (core_gnt)      mem_addr = core_addr;
    else if (host_gnt) mem_addr = host_addr;
    else               mem_addr = addr_q;
    addr_d        = mem_addr;
    mem_wdata     = host_gnt ? host_wdata : core_wdata;
    mem_wren      = (core_gnt && core_we) || (host_gnt && host_we);
    core_rvalid_d = core_gnt && !core_we;
    host_rvalid_d = host_gnt && !host_we;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_ARB;
      addr_q        <= '0;
      core_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_host_q   <= 1'b0;
`else
      starve_q      <= 4'd0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      core_rvalid_q <= core_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
`ifdef DMEM_ARB_RR_EN
      last_host_q   <= last_host_d;
`else
      starve_q      <= starve_d;
`endif
    end
  end

  // A read granted just before reset asserts must not surface as rvalid
  assign core_rvalid = core_rvalid_q && reset;
  assign host_rvalid = host_rvalid_q && reset;
  assign core_rdata  = mem_q;
  assign host_rdata  = mem_q;
  assign core_stall  = core_req && !core_gnt;
  assign host_locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  localparam int SL = 4;

  logic        clock, reset;
  logic        core_req, core_we, core_gnt, core_stall, core_rvalid;
  logic [15:0] core_addr, core_wdata, core_rdata;
  logic        host_req, host_we, host_lock, host_gnt, host_rvalid, host_locked;
  logic [15:0] host_addr, host_wdata, host_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_q;
  logic        mem_wren;

  dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_stall(core_stall),
    .core_rdata(core_rdata), .core_rvalid(core_rvalid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_lock(host_lock), .host_gnt(host_gnt),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_locked(host_locked),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous single-port RAM, 1-cycle read latency
  logic [15:0] ram [0:255];
  always @(posedge clock) begin
    if (mem_wren) ram[mem_addr[7:0]] <= mem_wdata;
    mem_q <= ram[mem_addr[7:0]];
  end

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  logic [15:0] ref_mem [0:255];
  bit          ref_known [0:255];
  bit          m_locked, m_last_host, e_cg, e_hg;
  int          m_starve, m_pend;  // m_pend: 0 none, 1 core, 2 host
  bit          m_pend_known;
  logic [15:0] m_pend_data, m_last_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_locked = 0; m_last_host = 0; m_starve = 0; m_pend = 0;
    m_pend_known = 0; m_last_addr = 16'h0;
  endtask

  // Inputs were applied at the falling edge; check mid-low-phase
  task automatic settle();
    #2;
    if (!reset) begin
      e_cg = 0; e_hg = 0;
    end else if (m_locked) begin
      e_cg = 0; e_hg = host_req;
    end else if (core_req && host_req) begin
`ifdef DMEM_ARB_RR_EN
      e_hg = !m_last_host;
`else
      e_hg = (m_starve == SL);
`endif
      e_cg = !e_hg;
    end else begin
      e_cg = core_req; e_hg = host_req;
    end
    chk("core_gnt", core_gnt, e_cg);
    chk("host_gnt", host_gnt, e_hg);
    chk("core_stall", core_stall, core_req && !e_cg);
    chk("mem_wren", mem_wren, (e_cg && core_we) || (e_hg && host_we));
    chk("mem_addr", mem_addr, e_cg ? core_addr : (e_hg ? host_addr : m_last_addr));
    if (e_cg && core_we) chk("mem_wdata_core", mem_wdata, core_wdata);
    if (e_hg && host_we) chk("mem_wdata_host", mem_wdata, host_wdata);
    chk("core_rvalid", core_rvalid, reset && m_pend == 1);
    chk("host_rvalid", host_rvalid, reset && m_pend == 2);
    if (reset && m_pend == 1 && m_pend_known) chk("core_rdata", core_rdata, m_pend_data);
    if (reset && m_pend == 2 && m_pend_known) chk("host_rdata", host_rdata, m_pend_data);
    chk("host_locked", host_locked, m_locked);
  endtask

  task automatic adv();
    @(posedge clock);
    if (!reset) begin
      model_reset();
    end else begin
      m_pend = 0;
      if (e_cg) begin
        m_last_addr = core_addr;
        if (core_we) begin
          ref_mem[core_addr[7:0]] = core_wdata; ref_known[core_addr[7:0]] = 1;
        end else begin
          m_pend = 1; m_pend_data = ref_mem[core_addr[7:0]];
          m_pend_known = ref_known[core_addr[7:0]];
        end
      end
      if (e_hg) begin
        m_last_addr = host_addr;
        if (host_we) begin
          ref_mem[host_addr[7:0]] = host_wdata; ref_known[host_addr[7:0]] = 1;
        end else begin
          m_pend = 2; m_pend_data = ref_mem[host_addr[7:0]];
          m_pend_known = ref_known[host_addr[7:0]];
        end
      end
      if (host_req && !e_hg) m_starve = (m_starve >= SL) ? SL : m_starve + 1;
      else m_starve = 0;
      if (!m_locked && core_req && host_req) m_last_host = e_hg;
      if (m_locked) m_locked = host_lock;
      else m_locked = host_lock && e_hg;
    end
    @(negedge clock);
  endtask

  task automatic set_core(input bit req, input bit we, input logic [15:0] a, input logic [15:0] d);
    core_req = req; core_we = we; core_addr = a; core_wdata = d;
  endtask

  task automatic set_host(input bit req, input bit we, input logic [15:0] a, input logic [15:0] d,
                          input bit lk);
    host_req = req; host_we = we; host_addr = a; host_wdata = d; host_lock = lk;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_known[i] = 0;
    model_reset();
    reset = 1'b0;
    set_core(1, 0, 16'h0, 16'h0);
    set_host(1, 0, 16'h1, 16'h0, 0);
    @(negedge clock);

    // Reset held with both requesting
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("rst_core_gnt", core_gnt, 1'b0);
      chk("rst_host_gnt", host_gnt, 1'b0);
      adv();
    end
    reset = 1'b1;
    settle();
`ifndef DMEM_ARB_RR_EN
    chk("release_core_gnt", core_gnt, 1'b1);
`endif
    adv();

    // Core only: write then read
    set_host(0, 0, 16'h0, 16'h0, 0);
    set_core(1, 1, 16'h0010, 16'hBEEF);
    settle(); chk("core_wr_gnt", core_gnt, 1'b1); adv();
    set_core(1, 0, 16'h0010, 16'h0);
    settle(); chk("core_rd_gnt", core_gnt, 1'b1); adv();
    set_core(0, 0, 16'h0, 16'h0);
    settle();
    chk("core_rd_valid", core_rvalid, 1'b1);
    chk("core_rd_data", core_rdata, 16'hBEEF);
    chk("core_rd_host_rvalid", host_rvalid, 1'b0);
    adv();

    // Continuous contention on reads
    for (int i = 0; i < 15; i++) begin
      set_core(1, 0, 16'h0010, 16'h0);
      set_host(1, 0, 16'h0010, 16'h0, 0);
      settle();
`ifndef DMEM_ARB_RR_EN
      chk("fixed_pattern", core_gnt, (i % 5) != 4);
`else
      if (i > 0) chk("rr_alternate", host_gnt, !m_last_host);
`endif
      adv();
    end

    // Lock burst: host writes 1..8 to 0..7
    set_core(0, 0, 16'h0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      set_host(1, 1, 16'(i), 16'(i + 1), 1);
      settle();
      if (i > 0) begin
        chk("lock_stall", core_stall, 1'b1);
        chk("lock_locked", host_locked, 1'b1);
      end
      adv();
      set_core(1, 0, 16'h0010, 16'h0);
    end
    set_host(0, 0, 16'h0, 16'h0, 0);
    settle(); chk("unlock_stall", core_stall, 1'b1); adv();
    settle(); chk("unlock_core_gnt", core_gnt, 1'b1); adv();
    set_core(1, 0, 16'h0003, 16'h0);
    settle(); chk("post_lock_rdata", core_rdata, 16'hBEEF); adv();
    set_core(0, 0, 16'h0, 16'h0);
    settle(); chk("lock_wr_rdata", core_rdata, 16'h0004); adv();

    // Core write then host read of same address
    set_core(1, 1, 16'h0020, 16'h1234);
    settle(); adv();
    set_core(0, 0, 16'h0, 16'h0);
    set_host(1, 0, 16'h0020, 16'h0, 0);
    settle(); adv();
    set_host(0, 0, 16'h0, 16'h0, 0);
    settle();
    chk("raw_host_rvalid", host_rvalid, 1'b1);
    chk("raw_host_rdata", host_rdata, 16'h1234);
    chk("raw_core_rvalid", core_rvalid, 1'b0);
    adv();

    // Reset mid-read while locking
    set_host(1, 0, 16'h0020, 16'h0, 1);
    settle(); chk("rstmid_gnt", host_gnt, 1'b1); adv();
    reset = 1'b0;
    settle(); chk("rstmid_rvalid", host_rvalid, 1'b0); adv();
    reset = 1'b1;
    set_host(1, 0, 16'h0020, 16'h0, 0);
    set_core(1, 0, 16'h0010, 16'h0);
    settle();
    chk("rstmid_unlocked", host_locked, 1'b0);
`ifndef DMEM_ARB_RR_EN
    chk("rstmid_core_first", core_gnt, 1'b1);
`endif
    adv();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) != 0);
      set_core($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
               16'($urandom_range(0, 15)), 16'($urandom));
      set_host($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
               16'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 5) == 0);
      settle();
      adv();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
